// File: rtl/spi_pkg.sv
// Shared constants for the SPI slave: bus addresses, status/control bit
// positions and the frame FSM encoding.
package spi_pkg;

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

  localparam int ST_IE  = 0;
  localparam int ST_RXV = 1;
  localparam int ST_TXF = 2;
  localparam int ST_OVR = 3;
  localparam int ST_UDR = 4;

  localparam int CTL_IE      = 0;
  localparam int CTL_CLR_OVR = 1;
  localparam int CTL_CLR_UDR = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one async input, plus a history flop that
// provides single-cycle rise/fall strobes in the clk domain.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_slave_wb.sv
// Mode-0 SPI slave bridged to an 8-bit, one-address-bit Wishbone-classic
// port: RX byte register with overrun, TX byte register with underrun.
//
// state | meaning
// IDLE  | cs_n deasserted, waiting for a frame to start
// SHIFT | frame active, bits move on synchronized sclk edges
module spi_slave_wb
  import spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF,
  parameter logic       IE_RST      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic       i_wb_cyc,
  input  logic       i_wb_we,
  input  logic       i_wb_addr,
  input  logic [7:0] i_wb_dat,
  output logic [7:0] o_wb_dat,
  output logic       o_wb_ack,
  output logic       o_int
);

  logic sclk_s, sclk_rise, sclk_fall;
  logic csn_s, csn_rise, csn_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_edges;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(spi_sclk),
    .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
    .clk(clk), .rst(rst), .din(spi_cs_n),
    .level(csn_s), .rise(csn_rise), .fall(csn_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(spi_mosi),
    .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_edges = ^{sclk_s, mosi_rise, mosi_fall};

  state_t     state_q, state_d;
  logic       frame_start, frame_abort;
  logic [2:0] bitcnt;
  logic [6:0] shift_rx;
  logic [6:0] shift_tx;
  logic       miso_q;
  logic [7:0] rx_data, tx_data;
  logic       rx_valid, tx_full, ovr, udr, ie;
  logic       ack_q;
  logic [7:0] wb_dat_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    frame_abort = 1'b0;
    case (state_q)
      IDLE: begin
        if (csn_fall) begin
          state_d     = SHIFT;
          frame_start = 1'b1;
        end
      end
      SHIFT: begin
        if (csn_rise) begin
          state_d     = IDLE;
          frame_abort = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A clock edge coinciding with cs_n release belongs to the discarded partial byte.
  logic       shift_rise, shift_fall, byte_done, tx_reload;
  logic [7:0] tx_load;

  assign shift_rise = (state_q == SHIFT) & sclk_rise & ~csn_rise;
  assign shift_fall = (state_q == SHIFT) & sclk_fall & ~csn_rise;
  assign byte_done  = shift_rise & (bitcnt == 3'd7);
  assign tx_reload  = frame_start | (shift_fall & (bitcnt == 3'd0));
  assign tx_load    = tx_full ? tx_data : IDLE_BYTE;

  logic       wb_fire, rd_data, wr_data, wr_ctrl;
  logic [7:0] status, rd_mux;

  assign wb_fire = i_wb_cyc & ~ack_q;
  assign rd_data = wb_fire & ~i_wb_we & (i_wb_addr == ADDR_DATA);
  assign wr_data = wb_fire &  i_wb_we & (i_wb_addr == ADDR_DATA);
  assign wr_ctrl = wb_fire &  i_wb_we & (i_wb_addr == ADDR_CTRL);

  always_comb begin
    status         = 8'h00;
    status[ST_IE]  = ie;
    status[ST_RXV] = rx_valid;
    status[ST_TXF] = tx_full;
    status[ST_OVR] = ovr;
    status[ST_UDR] = udr;
  end

  always_comb begin
    rd_mux = 8'h00;
    case (i_wb_addr)
      ADDR_DATA: rd_mux = rx_data;
      ADDR_CTRL: rd_mux = status;
      default:   rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bitcnt   <= 3'd0;
      shift_rx <= 7'd0;
      shift_tx <= 7'd0;
      miso_q   <= 1'b1;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      ovr      <= 1'b0;
      tx_data  <= IDLE_BYTE;
      tx_full  <= 1'b0;
      udr      <= 1'b0;
      ie       <= IE_RST;
      ack_q    <= 1'b0;
      wb_dat_q <= 8'h00;
    end else begin
      ack_q <= i_wb_cyc & ~ack_q;
      if (wb_fire & ~i_wb_we) wb_dat_q <= rd_mux;

      // Bus clears go first so a coincident SPI event is never lost.
      if (wr_ctrl) begin
        ie <= i_wb_dat[CTL_IE];
        if (i_wb_dat[CTL_CLR_OVR]) ovr <= 1'b0;
        if (i_wb_dat[CTL_CLR_UDR]) udr <= 1'b0;
      end
      if (rd_data) rx_valid <= 1'b0;

      if (frame_start | frame_abort) bitcnt <= 3'd0;
      if (shift_rise) begin
        shift_rx <= {shift_rx[5:0], mosi_s};
        bitcnt   <= bitcnt + 3'd1;
      end
      if (byte_done) begin
        rx_data  <= {shift_rx, mosi_s};
        rx_valid <= 1'b1;
        if (rx_valid & ~rd_data) ovr <= 1'b1;
      end

      if (tx_reload) begin
        shift_tx <= tx_load[6:0];
        miso_q   <= tx_load[7];
        if (tx_full) tx_full <= 1'b0;
        else         udr     <= 1'b1;
      end else if (shift_fall) begin
        shift_tx <= {shift_tx[5:0], 1'b0};
        miso_q   <= shift_tx[6];
      end

      // A write racing a reload lands after it and arms the following byte.
      if (wr_data) begin
        tx_data <= i_wb_dat;
        tx_full <= 1'b1;
      end
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = ~csn_s;
  assign o_wb_ack    = ack_q;
  assign o_wb_dat    = wb_dat_q;
  assign o_int       = rx_valid & ie;

endmodule

// File: tb/tb_spi_slave_wb.sv
// Scoreboarded bench for spi_slave_wb: bus reads push expected data, a
// monitor pops and compares on every ack; SPI master checks MISO and o_int.
module tb_spi_slave_wb;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic       cyc = 1'b0, we = 1'b0, addr = 1'b0;
  logic [7:0] wdat = 8'h00;
  logic       spi_miso, spi_miso_oe, o_wb_ack, o_int;
  logic [7:0] o_wb_dat;

  spi_slave_wb #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF), .IE_RST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .spi_sclk(sclk), .spi_cs_n(cs_n), .spi_mosi(mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .i_wb_cyc(cyc), .i_wb_we(we), .i_wb_addr(addr), .i_wb_dat(wdat),
    .o_wb_dat(o_wb_dat), .o_wb_ack(o_wb_ack), .o_int(o_int)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  bit         rd_q[$];
  logic [7:0] exp_q[$];
  string      nm_q[$];

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  bit         m_rd;
  logic [7:0] m_exp;
  string      m_nm;

  always @(negedge clk) begin
    if (rst && o_wb_ack) begin
      if (rd_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack actual=1 expected=0");
      end else begin
        m_rd  = rd_q.pop_front();
        m_exp = exp_q.pop_front();
        m_nm  = nm_q.pop_front();
        if (m_rd) check(m_nm, o_wb_dat, m_exp);
      end
    end
  end

  task automatic wb_xfer(input logic w, input logic a, input logic [7:0] d,
                         input logic [7:0] e, input string nm);
    int n;
    bit got;
    rd_q.push_back(!w);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(negedge clk);
    cyc = 1'b1; we = w; addr = a; wdat = d;
    n = 0; got = 0;
    while (!got && n < 8) begin
      @(negedge clk);
      n++;
      if (o_wb_ack) got = 1;
    end
    check({nm, "_lat"}, 8'(n), 8'd1);
    cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input logic a, input logic [7:0] e, input string nm);
    wb_xfer(1'b0, a, 8'h00, e, nm);
  endtask

  task automatic wb_write(input logic a, input logic [7:0] d, input string nm);
    wb_xfer(1'b1, a, d, 8'h00, nm);
  endtask

  task automatic cs_low(input string nm);
    @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    check({nm, "_oe"}, 8'(spi_miso_oe), 8'd1);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Mode-0 master, half period of 4 clk; MISO sampled just before each rise.
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, input bit chk_miso,
                          input logic [7:0] exp_miso, input bit chk_int, input string nm);
    logic [7:0] got;
    bit seen;
    got = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = tx[i];
      repeat (4) @(negedge clk);
      got[i] = spi_miso;
      if (chk_int && i == 0) check({nm, "_int_pre"}, 8'(o_int), 8'd0);
      sclk = 1'b1;
      if (chk_int && i == 0) begin
        seen = 0;
        for (int n = 0; n < 4; n++) begin
          @(negedge clk);
          if (o_int) seen = 1;
        end
        check({nm, "_int_lat"}, 8'(seen), 8'd1);
      end else begin
        repeat (4) @(negedge clk);
      end
      sclk = 1'b0;
    end
    if (chk_miso) check({nm, "_miso"}, got, exp_miso);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] pat;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ack", 8'(o_wb_ack), 8'd0);
    check("rst_dat", o_wb_dat, 8'h00);
    check("rst_int", 8'(o_int), 8'd0);
    check("rst_miso", 8'(spi_miso), 8'd1);
    check("rst_oe", 8'(spi_miso_oe), 8'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    wb_read(1'b1, 8'h01, "rst_ctrl");

    // single byte in
    cs_low("t1");
    spi_xfer(8'hA5, 8, 1, 8'hFF, 1, "t1");
    cs_high();
    check("t1_int_hi", 8'(o_int), 8'd1);
    wb_read(1'b0, 8'hA5, "t1_data");
    check("t1_int_lo", 8'(o_int), 8'd0);
    wb_read(1'b1, 8'h11, "t1_ctrl");
    wb_write(1'b1, 8'h05, "t1_clr");

    // echo out, then underrun frame
    wb_write(1'b0, 8'h3C, "t2_wr");
    wb_read(1'b1, 8'h05, "t2_ctrl_full");
    cs_low("t2");
    spi_xfer(8'h00, 8, 1, 8'h3C, 0, "t2_echo");
    cs_high();
    wb_read(1'b1, 8'h13, "t2_ctrl_a");
    wb_read(1'b0, 8'h00, "t2_data_a");
    cs_low("t2b");
    spi_xfer(8'h00, 8, 1, 8'hFF, 0, "t2_idle");
    cs_high();
    wb_read(1'b1, 8'h13, "t2_ctrl_b");
    wb_read(1'b0, 8'h00, "t2_data_b");
    wb_write(1'b1, 8'h07, "t2_clr");
    wb_read(1'b1, 8'h01, "t2_ctrl_c");

    // multi-byte frame, read between bytes
    cs_low("t3");
    for (int b = 1; b <= 4; b++) begin
      spi_xfer(8'(b), 8, 0, 8'h00, 0, "t3");
      wb_read(1'b0, 8'(b), "t3_data");
    end
    cs_high();
    wb_read(1'b1, 8'h11, "t3_ctrl");
    wb_write(1'b1, 8'h05, "t3_clr");

    // multi-byte frame, reads skipped -> overrun
    cs_low("t3b");
    for (int b = 1; b <= 4; b++) spi_xfer(8'(b), 8, 0, 8'h00, 0, "t3b");
    cs_high();
    wb_write(1'b1, 8'h05, "t3b_clr_udr");
    wb_read(1'b1, 8'h0B, "t3b_ctrl");
    wb_read(1'b0, 8'h04, "t3b_data");
    wb_write(1'b1, 8'h03, "t3b_clr_ovr");
    wb_read(1'b1, 8'h01, "t3b_ctrl2");

    // abort after 5 bits
    cs_low("t4");
    spi_xfer(8'hFF, 5, 0, 8'h00, 0, "t4_abort");
    cs_high();
    check("t4_int", 8'(o_int), 8'd0);
    wb_read(1'b1, 8'h11, "t4_ctrl");
    wb_write(1'b1, 8'h05, "t4_clr");
    cs_low("t4b");
    spi_xfer(8'hC3, 8, 1, 8'hFF, 0, "t4b");
    cs_high();
    wb_read(1'b0, 8'hC3, "t4b_data");
    wb_write(1'b1, 8'h05, "t4b_clr");

    // cyc held for 4 cycles -> two acks
    for (int k = 0; k < 2; k++) begin
      rd_q.push_back(1'b1);
      exp_q.push_back(8'h01);
      nm_q.push_back("hold_rd");
    end
    @(negedge clk);
    cyc = 1'b1; we = 1'b0; addr = 1'b1;
    pat[3] = o_wb_ack;
    for (int k = 2; k >= 0; k--) begin
      @(negedge clk);
      pat[k] = o_wb_ack;
    end
    cyc = 1'b0;
    check("hold_pat", {4'b0000, pat}, 8'h05);

    // interrupt disabled
    wb_write(1'b1, 8'h00, "t5_ie0");
    cs_low("t5");
    spi_xfer(8'h5A, 8, 1, 8'hFF, 0, "t5");
    cs_high();
    check("t5_int", 8'(o_int), 8'd0);
    wb_read(1'b1, 8'h12, "t5_ctrl");

    // reset mid-frame
    cs_low("t6");
    spi_xfer(8'hFF, 3, 0, 8'h00, 0, "t6");
    #2;
    rst = 1'b0;
    #1;
    check("t6_ack", 8'(o_wb_ack), 8'd0);
    check("t6_dat", o_wb_dat, 8'h00);
    check("t6_int", 8'(o_int), 8'd0);
    check("t6_miso", 8'(spi_miso), 8'd1);
    check("t6_oe", 8'(spi_miso_oe), 8'd0);
    @(negedge clk);
    cs_n = 1'b1; sclk = 1'b0;
    rd_q.delete(); exp_q.delete(); nm_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    wb_read(1'b1, 8'h01, "t6_ctrl");

    repeat (5) @(negedge clk);
    check("sb_drain", 8'(rd_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave_wb.md
Name: spi_slave_wb

Overview:
- SPI slave peripheral that sits directly below the boot loader FSM. It converts serial traffic from the external programmer into byte reads and writes on an 8-bit single-address-bit Wishbone-classic port.
- Raises a level interrupt when a received byte is waiting. Returns a TX byte on MISO during the next byte frame.
- SPI mode 0 only (CPOL=0, CPHA=0), MSB first. All SPI inputs are oversampled in the clk domain; requires f_sclk <= f_clk/8.

Parameters:
- SYNC_STAGES, 2: synchronizer flops on sclk/cs_n/mosi (min 2).
- IDLE_BYTE, 8'hFF: byte shifted out when no TX byte is loaded.
- IE_RST, 1'b1: reset value of the interrupt enable. The boot loader never programs it.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- spi_sclk  in  1  SPI clock from master (async).
- spi_cs_n  in  1  chip select, active low (async).
- spi_mosi  in  1  master-out data (async).
- spi_miso  out  1  slave-out data.
- spi_miso_oe  out  1  MISO output enable, equals synchronized ~cs_n.
- i_wb_cyc  in  1  bus cycle request.
- i_wb_we  in  1  1=write, 0=read.
- i_wb_addr  in  1  0=DATA, 1=CTRL/STATUS.
- i_wb_dat  in  8  write data.
- o_wb_dat  out  8  read data, valid while o_wb_ack=1.
- o_wb_ack  out  1  single-cycle acknowledge.
- o_int  out  1  level interrupt = rx_valid & ie.

Behaviour:
- Reset (rst=0, async):
  - Outputs: o_wb_ack=0, o_wb_dat=0, o_int=0, spi_miso=1, spi_miso_oe=0.
  - State: rx_data=0, rx_valid=0, ovr=0, tx_data=IDLE_BYTE, tx_full=0, udr=0, ie=IE_RST, bitcnt=0, FSM=IDLE.
- Sync and edges: each SPI input passes SYNC_STAGES flops plus one history flop.
  - rise = sclk_s & ~sclk_d, fall = ~sclk_s & sclk_d; csn_fall/csn_rise defined the same way.
- Frame FSM, states IDLE and SHIFT:
  - IDLE -> SHIFT on csn_fall.
    - Load shift_tx from tx_data if tx_full (then clear tx_full); otherwise load IDLE_BYTE and set udr.
    - Drive MSB on spi_miso.
  - SHIFT, on rise:
    - shift_rx <= {shift_rx[6:0], mosi_s}; bitcnt++.
    - When bitcnt wraps 7->0: rx_data <= completed byte, rx_valid <= 1. If rx_valid was already 1, set ovr (the old byte is lost).
  - SHIFT, on fall:
    - Shift shift_tx left and drive the new MSB.
    - If bitcnt==0 (byte boundary), reload shift_tx from tx_data/IDLE_BYTE with the same tx_full/udr rules as at frame start.
  - SHIFT -> IDLE on csn_rise at any bitcnt. The partial byte is discarded, bitcnt=0, rx_valid unchanged.
- Latency: rx_valid and o_int go high on the clk cycle after the synchronized 8th rise is detected, which is <= SYNC_STAGES+2 clk after the pin edge.
- Wishbone handshake:
  - Registered ack: o_wb_ack <= i_wb_cyc & ~o_wb_ack.
  - Ack arrives 1 cycle after cyc rises. A master that drops cyc on ack sees exactly one ack.
  - Side effects happen only on the cycle ack is asserted.
- Register map:
  - Read DATA: o_wb_dat=rx_data; clears rx_valid.
  - Write DATA: tx_data<=i_wb_dat, tx_full<=1. Writing while tx_full overwrites silently.
  - Read CTRL: {3'b0, udr, ovr, tx_full, rx_valid, ie}.
  - Write CTRL: bit0 -> ie; bit1=1 clears ovr; bit2=1 clears udr.
- Simultaneous events:
  - Byte completion in the same cycle as an acked DATA read: the read returns the old rx_data, and rx_valid stays 1 with the new byte. ovr is not set because the old byte was consumed.
  - DATA write in the same cycle as a TX reload: the reload takes the old tx_data (or IDLE_BYTE if empty). The new write sets tx_full for the next byte.
- o_int is combinational from registers, with no extra latency.

Decomposition:
- Package spi_pkg holds the constants:
  - ADDR_DATA=1'b0, ADDR_CTRL=1'b1.
  - Status bit indices: ST_IE=0, ST_RXV=1, ST_TXF=2, ST_OVR=3, ST_UDR=4.
  - Control bits: CTL_IE=0, CTL_CLR_OVR=1, CTL_CLR_UDR=2.
  - FSM encoding: IDLE, SHIFT.
- One sub-module, spi_sync_edge: SYNC_STAGES synchronizer plus history flop for one signal, outputting level, rise and fall. It is instantiated 3 times.

Test Plan:
- Single byte in: pulse cs_n low, master sends 8'hA5 with sclk=clk/8, cs_n high -> o_int=1 within SYNC_STAGES+2 clk of the 8th rising edge. A DATA read acks 1 cycle after cyc and returns 8'hA5. o_int drops the next cycle.
- Echo out: write DATA 8'h3C before cs_n falls, then send any byte -> master samples 8'h3C on MISO and tx_full reads 0. A second frame with no write returns 8'hFF and CTRL bit4 (udr)=1.
- Multi-byte frame, 4 bytes 01,02,03,04 under one cs_n, each read before the next completes -> reads return 01..04 in order and ovr stays 0. Skipping the reads -> DATA=04, CTRL reads 8'h0B (ovr, rxv, ie).
- Abort mid-byte: cs_n rises after 5 bits -> rx_valid stays 0, o_int stays 0. The next full byte 8'hC3 is received correctly.
- Handshake and reset:
  - Hold cyc high for 4 cycles -> ack pattern 0,1,0,1.
  - Assert rst low mid-frame -> every output returns to its reset value immediately.
  - Write CTRL 8'h00 then receive a byte -> rx_valid=1 and o_int=0.
